// File: rtl/pll_reset_sequencer.sv
// Turns the PLL lock indicator into a qualified, synchronous reset for the PLL clock domain.
// Lock must be stable for a window, reset is then held a fixed time, and lock losses in RUN are counted.
module pll_reset_sequencer #(
  parameter int SYNC_STAGES        = 2,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int RESET_HOLD_CYCLES  = 16,
  parameter int LOSS_CNT_W         = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  locked,
  input  logic                  clear_loss,
  output logic                  rst_out,
  output logic                  ready,
  output logic                  lock_lost,
  output logic [LOSS_CNT_W-1:0] loss_count,
  output logic [1:0]            state_o
);

  localparam int MAX_CYC = (LOCK_STABLE_CYCLES > RESET_HOLD_CYCLES) ? LOCK_STABLE_CYCLES
                                                                    : RESET_HOLD_CYCLES;
  localparam int CNT_W = ($clog2(MAX_CYC) < 1) ? 1 : $clog2(MAX_CYC);

  localparam logic [CNT_W-1:0]      STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]      HOLD_LAST   = CNT_W'(RESET_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]      CNT_ONE     = CNT_W'(1);
  localparam logic [LOSS_CNT_W-1:0] LOSS_ONE    = LOSS_CNT_W'(1);
  localparam logic [LOSS_CNT_W-1:0] LOSS_MAX    = '1;

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("pll_reset_sequencer: SYNC_STAGES must be >= 2");
  end
  if (LOCK_STABLE_CYCLES < 1) begin : g_bad_stable
    $error("pll_reset_sequencer: LOCK_STABLE_CYCLES must be >= 1");
  end
  if (RESET_HOLD_CYCLES < 1) begin : g_bad_hold
    $error("pll_reset_sequencer: RESET_HOLD_CYCLES must be >= 1");
  end
  if (LOSS_CNT_W < 1) begin : g_bad_loss_w
    $error("pll_reset_sequencer: LOSS_CNT_W must be >= 1");
  end

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } state_t;

  state_t                 state, next_state;
  logic [CNT_W-1:0]       cnt, next_cnt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lock_s;
  logic                   loss_event;

  assign lock_s     = sync_q[SYNC_STAGES-1];
  assign loss_event = (state == RUN) && !lock_s;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      state  <= WAIT_LOCK;
      cnt    <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], locked};
      state  <= next_state;
      cnt    <= next_cnt;
    end
  end

  // NOTE: defaults assigned first so no path through this block can infer a latch.
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    unique case (state)
      WAIT_LOCK: begin
        if (lock_s) begin
          next_state = STABLE;
          next_cnt   = '0;
        end
      end
      STABLE: begin
        if (!lock_s) begin
          next_state = WAIT_LOCK;
          next_cnt   = '0;
        end else if (cnt == STABLE_LAST) begin
          next_state = HOLD;
          next_cnt   = '0;
        end else begin
          next_cnt = cnt + CNT_ONE;
        end
      end
      HOLD: begin
        if (!lock_s) begin
          next_state = WAIT_LOCK;
          next_cnt   = '0;
        end else if (cnt == HOLD_LAST) begin
          next_state = RUN;
          next_cnt   = '0;
        end else begin
          next_cnt = cnt + CNT_ONE;
        end
      end
      RUN: begin
        if (!lock_s) begin
          next_state = WAIT_LOCK;
          next_cnt   = '0;
        end
      end
      default: begin
        next_state = WAIT_LOCK;
        next_cnt   = '0;
      end
    endcase
  end

  // A loss coinciding with clear_loss wins: the counter restarts at one.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_lost  <= 1'b0;
      loss_count <= '0;
    end else if (loss_event) begin
      lock_lost  <= 1'b1;
      if (clear_loss) begin
        loss_count <= LOSS_ONE;
      end else if (loss_count != LOSS_MAX) begin
        loss_count <= loss_count + LOSS_ONE;
      end
    end else if (clear_loss) begin
      lock_lost  <= 1'b0;
      loss_count <= '0;
    end
  end

  assign rst_out = (state != RUN);
  assign ready   = (state == RUN);
  assign state_o = state;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: two instances (8/4 and 1/1 windows) share stimulus and are
// checked every cycle against a lock-streak model plus literal timing expectations.
module tb_pll_reset_sequencer;

  localparam int S    = 2;
  localparam int W    = 2;
  localparam int LMAX = (1 << W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic locked = 1'b0;
  logic clear_loss = 1'b0;

  logic [1:0]   rst_out_v, ready_v, lost_v;
  logic [1:0]   state_v [2];
  logic [W-1:0] cnt_v   [2];

  always #5 clk = ~clk;

  pll_reset_sequencer #(
    .SYNC_STAGES(S), .LOCK_STABLE_CYCLES(8), .RESET_HOLD_CYCLES(4), .LOSS_CNT_W(W)
  ) u_a (
    .clk(clk), .rst(rst), .locked(locked), .clear_loss(clear_loss),
    .rst_out(rst_out_v[0]), .ready(ready_v[0]), .lock_lost(lost_v[0]),
    .loss_count(cnt_v[0]), .state_o(state_v[0])
  );

  pll_reset_sequencer #(
    .SYNC_STAGES(S), .LOCK_STABLE_CYCLES(1), .RESET_HOLD_CYCLES(1), .LOSS_CNT_W(W)
  ) u_b (
    .clk(clk), .rst(rst), .locked(locked), .clear_loss(clear_loss),
    .rst_out(rst_out_v[1]), .ready(ready_v[1]), .lock_lost(lost_v[1]),
    .loss_count(cnt_v[1]), .state_o(state_v[1])
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the phase is a pure function of how many consecutive edges have seen lock_s = 1.
  int         m_streak [2] = '{0, 0};
  logic [S-1:0] m_hist [2] = '{'0, '0};
  bit         m_lost   [2] = '{1'b0, 1'b0};
  int         m_cnt    [2] = '{0, 0};

  function automatic int win_stable(input int i);
    return (i == 0) ? 8 : 1;
  endfunction

  function automatic int win_hold(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  function automatic int m_phase(input int i);
    if (m_streak[i] == 0) return 0;
    if (m_streak[i] <= win_stable(i)) return 1;
    if (m_streak[i] <= win_stable(i) + win_hold(i)) return 2;
    return 3;
  endfunction

  always @(posedge clk) begin
    bit ls, was_run;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_hist[i]   = '0;
        m_streak[i] = 0;
        m_lost[i]   = 1'b0;
        m_cnt[i]    = 0;
      end else begin
        ls      = m_hist[i][S-1];
        was_run = (m_phase(i) == 3);
        if (ls) begin
          if (m_streak[i] < 100000) m_streak[i]++;
        end else begin
          m_streak[i] = 0;
        end
        if (!ls && was_run) begin
          m_lost[i] = 1'b1;
          m_cnt[i]  = clear_loss ? 1 : ((m_cnt[i] < LMAX) ? m_cnt[i] + 1 : LMAX);
        end else if (clear_loss) begin
          m_lost[i] = 1'b0;
          m_cnt[i]  = 0;
        end
        m_hist[i] = {m_hist[i][S-2:0], locked};
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int i = 0; i < 2; i++) begin
        check(i == 0 ? "cycle_a" : "cycle_b",
              {25'd0, state_v[i], rst_out_v[i], ready_v[i], lost_v[i], cnt_v[i]},
              {25'd0, 2'(m_phase(i)), m_phase(i) != 3, m_phase(i) == 3, m_lost[i], W'(m_cnt[i])});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  // Expects rst just released with locked = 1 and sync flops cleared.
  task automatic startup_check(input string tag);
    for (int k = 1; k <= 15; k++) begin
      tick();
      if (k == 2)  check({tag, "_a_state_e2"}, state_v[0], 0);
      if (k == 3)  check({tag, "_a_state_e3"}, state_v[0], 1);
      if (k == 4)  check({tag, "_b_rst_e4"}, rst_out_v[1], 1);
      if (k == 5)  check({tag, "_b_rst_e5"}, rst_out_v[1], 0);
      if (k == 11) check({tag, "_a_state_e11"}, state_v[0], 2);
      if (k == 14) check({tag, "_a_rst_e14"}, rst_out_v[0], 1);
      if (k == 15) begin
        check({tag, "_a_rst_e15"}, rst_out_v[0], 0);
        check({tag, "_a_state_e15"}, state_v[0], 3);
      end
    end
  endtask

  task automatic wait_run_a(input string tag, input int expect_edges);
    int n = 0;
    do begin
      tick();
      n++;
    end while (rst_out_v[0] && n < 40);
    check(tag, n, expect_edges);
  endtask

  initial begin
    int hi;
    int seg_len;

    rst = 1'b1;
    locked = 1'b1;
    tick();
    cmp_en = 1'b1;
    check("reset_state", {state_v[0], rst_out_v[0], ready_v[0], lost_v[0], cnt_v[0]}, 7'b00_1_0_0_00);
    tick();
    rst = 1'b0;
    startup_check("pwr");

    // Reset mid-RUN
    rst = 1'b1;
    tick();
    check("rst_run_state", state_v[0], 0);
    check("rst_run_rst_out", rst_out_v[0], 1);
    check("rst_run_loss_count", cnt_v[0], 0);
    rst = 1'b0;
    startup_check("rst_run");

    // Drop lock mid-STABLE at cnt = 5
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ticks(8);
    check("mid_stable_state", state_v[0], 1);
    locked = 1'b0;
    ticks(3);
    check("mid_stable_back_to_wait", state_v[0], 0);
    locked = 1'b1;
    wait_run_a("mid_stable_rerun_edges", 15);
    check("mid_stable_lock_lost", lost_v[0], 0);
    check("mid_stable_loss_count", cnt_v[0], 0);

    // Loss in RUN
    locked = 1'b0;
    tick();
    check("loss_rst_out_e1", rst_out_v[0], 0);
    tick();
    check("loss_rst_out_e2", rst_out_v[0], 0);
    tick();
    check("loss_rst_out_e3", rst_out_v[0], 1);
    check("loss_lock_lost", lost_v[0], 1);
    check("loss_count_1", cnt_v[0], 1);
    tick();
    locked = 1'b1;
    wait_run_a("loss_relock_edges", 15);

    // One-cycle glitch in RUN
    locked = 1'b0;
    tick();
    locked = 1'b1;
    hi = int'(rst_out_v[1]);
    for (int k = 0; k < 12; k++) begin
      tick();
      hi += int'(rst_out_v[1]);
    end
    check("glitch_b_rst_high_ge3", hi >= 3, 1);
    ticks(10);

    // Three more losses: counter saturates
    for (int k = 0; k < 3; k++) begin
      locked = 1'b0;
      ticks(4);
      locked = 1'b1;
      ticks(16);
    end
    check("sat_loss_count", cnt_v[0], LMAX);
    clear_loss = 1'b1;
    tick();
    clear_loss = 1'b0;
    check("clear_loss_count", cnt_v[0], 0);
    check("clear_lock_lost", lost_v[0], 0);

    // clear_loss coinciding with a loss
    locked = 1'b0;
    ticks(2);
    clear_loss = 1'b1;
    tick();
    clear_loss = 1'b0;
    check("coincide_loss_count", cnt_v[0], 1);
    check("coincide_lock_lost", lost_v[0], 1);
    tick();
    locked = 1'b1;
    ticks(16);

    // Reset mid-HOLD
    locked = 1'b0;
    ticks(4);
    locked = 1'b1;
    ticks(12);
    check("hold_state", state_v[0], 2);
    rst = 1'b1;
    tick();
    check("rst_hold_state", state_v[0], 0);
    check("rst_hold_rst_out", rst_out_v[0], 1);
    check("rst_hold_loss_count", cnt_v[0], 0);
    rst = 1'b0;
    startup_check("rst_hold");

    // Randomized segments, checked cycle by cycle against the model
    for (int seg = 0; seg < 40; seg++) begin
      locked  = ($urandom_range(0, 3) != 0);
      seg_len = locked ? int'($urandom_range(1, 25)) : int'($urandom_range(1, 4));
      for (int k = 0; k < seg_len; k++) begin
        clear_loss = ($urandom_range(0, 15) == 0);
        rst        = ($urandom_range(0, 99) == 0);
        tick();
      end
    end
    rst = 1'b0;
    clear_loss = 1'b0;
    ticks(3);

    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
